mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 127 ++++++++++++
 tb/tb_mem_lsu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit between the memory stage and a
// simple req/ack data memory. It checks legality, issues one word-aligned bus
// request and sign/zero-extends the returned load data into Rdata_ext_M.
module mem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_M,
  input  logic        mem_we_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] wdata_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] Rdata_ext_M,
  output logic        lsu_stall,
  output logic        access_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [1:0]  off_q;   // byte offset of the latched access
  logic [2:0]  f3_q;    // latched size/sign
  logic        legal;
  logic        start;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_ext;
  logic [31:0] rd_sh;

  // Legality of the incoming access: opcode subset plus natural alignment.
  always_comb begin
    legal = 1'b0;
    if (mem_we_M) legal = (funct3_M[2] == 1'b0) && (funct3_M[1:0] != 2'b11);
    else          legal = (funct3_M[1:0] != 2'b11) && (funct3_M != 3'b110);
    if (funct3_M[1:0] == 2'b01 && ALU_result_M[0])            legal = 1'b0;
    if (funct3_M[1:0] == 2'b10 && ALU_result_M[1:0] != 2'b00) legal = 1'b0;
  end

  assign start = (state == IDLE) && mem_req_M;

  // Stall and error are combinational so the pipeline freezes in the request
  // cycle itself; both are held low while reset is asserted.
  assign lsu_stall  = rst_n && ((start && legal) || (state == BUSY));
  assign access_err = rst_n && start && !legal;

  // Store strobes and lane-replicated data for the incoming access.
  always_comb begin
    strb_n  = 4'b0000;
    wdata_n = wdata_M;
    case (funct3_M[1:0])
      2'b00: begin
        strb_n  = 4'b0001 << ALU_result_M[1:0];
        wdata_n = {4{wdata_M[7:0]}};
      end
      2'b01: begin
        strb_n  = 4'b0011 << ALU_result_M[1:0];
        wdata_n = {2{wdata_M[15:0]}};
      end
      default: begin
        strb_n  = 4'b1111;
        wdata_n = wdata_M;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend.
  always_comb begin
    rd_sh  = dm_rdata >> {off_q, 3'b000};
    ld_ext = dm_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_ext = {24'b0, rd_sh[7:0]};
      3'b101:  ld_ext = {16'b0, rd_sh[15:0]};
      default: ld_ext = dm_rdata;
    endcase
  end

  // Control FSM with registered bus outputs; DONE is a one-cycle guard so a
  // still-high mem_req_M from the finishing instruction is not re-issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= 32'b0;
      dm_wstrb    <= 4'b0;
      dm_wdata    <= 32'b0;
      Rdata_ext_M <= 32'b0;
      off_q       <= 2'b0;
      f3_q        <= 3'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && legal) begin
            state    <= BUSY;
            dm_req   <= 1'b1;
            dm_we    <= mem_we_M;
            dm_addr  <= {ALU_result_M[31:2], 2'b00};
            dm_wstrb <= mem_we_M ? strb_n : 4'b0000;
            dm_wdata <= mem_we_M ? wdata_n : 32'b0;
            off_q    <= ALU_result_M[1:0];
            f3_q     <= funct3_M;
          end
        end
        BUSY: begin
          if (dm_ack) begin
            state    <= DONE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_wstrb <= 4'b0000;
            if (!dm_we) Rdata_ext_M <= ld_ext;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus randomized accesses checked
// against a transaction-level model of legality, strobes, data and extension.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_M = 1'b0;
  logic        mem_we_M = 1'b0;
  logic [2:0]  funct3_M = 3'b0;
  logic [31:0] ALU_result_M = 32'b0;
  logic [31:0] wdata_M = 32'b0;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'b0;
  logic [31:0] Rdata_ext_M;
  logic        lsu_stall;
  logic        access_err;

  int n_chk = 0;
  int n_err = 0;
  int req_cycles = 0;
  int exp_req_cycles = 0;
  logic [31:0] ref_rdata = 32'b0;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .mem_req_M(mem_req_M), .mem_we_M(mem_we_M),
    .funct3_M(funct3_M), .ALU_result_M(ALU_result_M), .wdata_M(wdata_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .Rdata_ext_M(Rdata_ext_M), .lsu_stall(lsu_stall), .access_err(access_err)
  );

  always #5 clk = ~clk;

  // Count every cycle the bus request is seen high.
  always @(negedge clk) if (dm_req === 1'b1) req_cycles++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'd3) return 1'b0;
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && f3 == 3'd6) return 1'b0;
    return (a % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int off, sz;
    s = 4'b0; off = int'(a[1:0]); sz = m_size(f3);
    for (int b = 0; b < 4; b++) if (b >= off && b < off + sz) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int sz;
    w = 32'b0; sz = m_size(f3);
    for (int b = 0; b < 4; b++) w[8*b +: 8] = wd[8*(b % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = m_size(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    v = (rd >> (8 * int'(a[1:0]))) & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // One instruction: request cycle, dly+1 BUSY cycles (ack in the last), DONE.
  // Entered just after a rising edge; returns just after the edge leaving DONE
  // (or the request cycle for an illegal access) with mem_req_M dropped.
  task automatic access(input string nm, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
    bit lg;
    int stalls;
    lg = m_legal(we, f3, a);
    mem_req_M = 1'b1; mem_we_M = we; funct3_M = f3; ALU_result_M = a; wdata_M = wd;
    dm_ack = 1'b0;
    @(negedge clk);
    chk({nm, ":req_stall"}, 32'(lsu_stall), 32'(lg));
    chk({nm, ":req_err"}, 32'(access_err), 32'(!lg));
    chk({nm, ":req_dmreq"}, 32'(dm_req), 32'd0);
    stalls = lsu_stall ? 1 : 0;
    @(posedge clk); #1;
    if (!lg) begin
      mem_req_M = 1'b0;
      @(negedge clk);
      chk({nm, ":err_pulse"}, 32'(access_err), 32'd0);
      chk({nm, ":err_nodmreq"}, 32'(dm_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    for (int k = 0; k <= dly; k++) begin
      if (k == dly) begin dm_ack = 1'b1; dm_rdata = rd; end
      else begin dm_ack = 1'b0; dm_rdata = $urandom; end
      @(negedge clk);
      exp_req_cycles++;
      if (lsu_stall) stalls++;
      chk({nm, ":busy_req"}, 32'(dm_req), 32'd1);
      chk({nm, ":busy_addr"}, dm_addr, {a[31:2], 2'b00});
      chk({nm, ":busy_we"}, 32'(dm_we), 32'(we));
      chk({nm, ":busy_strb"}, 32'(dm_wstrb), we ? 32'(m_strb(f3, a)) : 32'd0);
      if (we) chk({nm, ":busy_wdata"}, dm_wdata, m_wdata(f3, wd));
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    if (!we) ref_rdata = m_load(f3, a, rd);
    @(negedge clk);
    chk({nm, ":stall_cycles"}, 32'(stalls), 32'(dly + 2));
    chk({nm, ":done_stall"}, 32'(lsu_stall), 32'd0);
    chk({nm, ":done_req"}, 32'(dm_req), 32'd0);
    chk({nm, ":rdata"}, Rdata_ext_M, ref_rdata);
    @(posedge clk); #1;
    mem_req_M = 1'b0;
  endtask

  // Idle cycle, optionally with a stray ack that must be ignored.
  task automatic idle_cycle(input bit stray);
    mem_req_M = 1'b0;
    dm_ack = stray; dm_rdata = $urandom;
    @(negedge clk);
    chk("idle_req", 32'(dm_req), 32'd0);
    chk("idle_stall", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("idle_rdata", Rdata_ext_M, ref_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          we;
    // Reset with a legal request pending: everything forced low.
    mem_req_M = 1'b1; funct3_M = 3'b010; ALU_result_M = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_err", 32'(access_err), 32'd0);
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_rdata", Rdata_ext_M, 32'd0);
    mem_req_M = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    access("lb_sign", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
    chk("lb_sign_val", Rdata_ext_M, 32'hFFFF_FF80);
    access("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0);
    chk("lhu_val", Rdata_ext_M, 32'h0000_BEEF);
    access("sb", 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h1234_5678, 0);
    chk("sb_keep", Rdata_ext_M, 32'h0000_BEEF);
    access("lw_mis", 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0);
    idle_cycle(1'b1);

    // Back-to-back LW then SW with only the DONE cycle between them.
    access("b2b_lw", 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 0);
    access("b2b_sw", 1'b1, 3'b010, 32'h0000_6004, 32'h1122_3344, 32'h0, 1);
    chk("b2b_keep", Rdata_ext_M, 32'hCAFE_F00D);

    // Reset in the middle of BUSY, then a late ack.
    mem_req_M = 1'b1; mem_we_M = 1'b0; funct3_M = 3'b010; ALU_result_M = 32'h5000;
    @(posedge clk); #1;
    mem_req_M = 1'b0;
    @(negedge clk);
    exp_req_cycles++;
    chk("mid_busy_req", 32'(dm_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dm_req), 32'd0);
    chk("mid_rst_stall", 32'(lsu_stall), 32'd0);
    chk("mid_rst_we", 32'(dm_we), 32'd0);
    chk("mid_rst_strb", 32'(dm_wstrb), 32'd0);
    chk("mid_rst_addr", dm_addr, 32'd0);
    chk("mid_rst_rdata", Rdata_ext_M, 32'd0);
    ref_rdata = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle(1'b1);
    access("post_rst", 1'b0, 3'b100, 32'h0000_7002, 32'h0, 32'h00A5_0000, 0);
    chk("post_rst_val", Rdata_ext_M, 32'h0000_00A5);

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(m_size(f3)) - 32'd1);
      access("rnd", we, f3, a, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    chk("req_cycles", 32'(req_cycles), 32'(exp_req_cycles));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
